sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_sram_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Two-port (CPU / debug loader) arbiter in front of an asynchronous 16-bit SRAM.
// Round-robin on ties; every SRAM strobe and port output comes straight from a flop.
module sram_arbiter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,

    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_ready,

    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [15:0] dbg_addr,
    input  logic [15:0] dbg_wdata,
    output logic [15:0] dbg_rdata,
    output logic        dbg_ready,

    output logic [1:0]  gnt,

    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_UB_N,
    output logic [19:0] SRAM_ADDR,
    inout  wire  [15:0] SRAM_DQ
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10,
        DONE   = 2'b11
    } state_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_CPU  = 2'b01;
    localparam logic [1:0] OWN_DBG  = 2'b10;
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  owner_q, owner_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        last_dbg_q, last_dbg_d;

    logic        ce_n_q, ce_n_d;
    logic        oe_n_q, oe_n_d;
    logic        we_n_q, we_n_d;
    logic        dq_oe_q, dq_oe_d;
    logic [19:0] sram_addr_q, sram_addr_d;
    logic [1:0]  gnt_q, gnt_d;
    logic        cpu_ready_q, cpu_ready_d;
    logic        dbg_ready_q, dbg_ready_d;
    logic [15:0] cpu_rdata_q, cpu_rdata_d;
    logic [15:0] dbg_rdata_q, dbg_rdata_d;

    logic        pick_dbg_s;
    logic        active_s;
    logic        xfer_s;
    logic        capture_s;

    // Next-state, transaction latch and arbitration
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        last_dbg_d = last_dbg_q;
        pick_dbg_s = 1'b0;

        case (state_q)
            IDLE: begin
                if (cpu_req || dbg_req) begin
                    // Debug wins only when alone, or on a tie when the CPU was served last.
                    pick_dbg_s = dbg_req && (!cpu_req || !last_dbg_q);
                    last_dbg_d = pick_dbg_s;
                    state_d    = SETUP;
                    if (pick_dbg_s) begin
                        owner_d = OWN_DBG;
                        we_d    = dbg_we;
                        addr_d  = dbg_addr;
                        wdata_d = dbg_wdata;
                    end else begin
                        owner_d = OWN_CPU;
                        we_d    = cpu_we;
                        addr_d  = cpu_addr;
                        wdata_d = cpu_wdata;
                    end
                end else begin
                    owner_d = OWN_NONE;
                    state_d = IDLE;
                end
            end
            SETUP: begin
                cnt_d   = CNT_LOAD;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so every strobe is registered
    always_comb begin
        active_s  = (state_d != IDLE);
        xfer_s    = (state_d == ACCESS) || (state_d == DONE);
        capture_s = (state_q == ACCESS) && (cnt_q == 4'd0) && !we_q;

        ce_n_d      = !active_s;
        oe_n_d      = !(xfer_s && !we_d);
        we_n_d      = !((state_d == ACCESS) && we_d);
        dq_oe_d     = xfer_s && we_d;
        sram_addr_d = active_s ? {4'b0000, addr_d} : 20'h00000;
        gnt_d       = active_s ? owner_d : OWN_NONE;
        cpu_ready_d = (state_d == DONE) && (owner_d == OWN_CPU);
        dbg_ready_d = (state_d == DONE) && (owner_d == OWN_DBG);

        if (capture_s && (owner_q == OWN_CPU)) begin
            cpu_rdata_d = SRAM_DQ;
        end else begin
            cpu_rdata_d = cpu_rdata_q;
        end
        if (capture_s && (owner_q == OWN_DBG)) begin
            dbg_rdata_d = SRAM_DQ;
        end else begin
            dbg_rdata_d = dbg_rdata_q;
        end
    end

    // State and output registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            owner_q     <= OWN_NONE;
            we_q        <= 1'b0;
            addr_q      <= 16'h0000;
            wdata_q     <= 16'h0000;
            last_dbg_q  <= 1'b1;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            dq_oe_q     <= 1'b0;
            sram_addr_q <= 20'h00000;
            gnt_q       <= OWN_NONE;
            cpu_ready_q <= 1'b0;
            dbg_ready_q <= 1'b0;
            cpu_rdata_q <= 16'h0000;
            dbg_rdata_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            last_dbg_q  <= last_dbg_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            dq_oe_q     <= dq_oe_d;
            sram_addr_q <= sram_addr_d;
            gnt_q       <= gnt_d;
            cpu_ready_q <= cpu_ready_d;
            dbg_ready_q <= dbg_ready_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    assign SRAM_CE_N = ce_n_q;
    assign SRAM_LB_N = ce_n_q;
    assign SRAM_UB_N = ce_n_q;
    assign SRAM_OE_N = oe_n_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_ADDR = sram_addr_q;
    assign SRAM_DQ   = dq_oe_q ? wdata_q : 16'hzzzz;

    assign gnt       = gnt_q;
    assign cpu_ready = cpu_ready_q;
    assign dbg_ready = dbg_ready_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: directed transactions push expectations,
// a negedge monitor pops them whenever a ready pulse appears.
module tb_sram_arbiter;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic        rst;
    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [15:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic [15:0] cpu_rdata, dbg_rdata;
    logic        cpu_ready, dbg_ready;
    logic [1:0]  gnt;
    logic        ce_n, oe_n, we_n, lb_n, ub_n;
    logic [19:0] sram_addr;
    wire  [15:0] dq;

    // Second build with a single wait cycle; debug port left idle.
    logic        c1_req;
    logic [15:0] c1_addr;
    logic [15:0] c1_rdata, c1_dbg_rdata;
    logic        c1_ready, c1_dbg_ready;
    logic [1:0]  c1_gnt;
    logic        c1_ce_n, c1_oe_n, c1_we_n, c1_lb_n, c1_ub_n;
    logic [19:0] c1_sram_addr;
    wire  [15:0] dq1;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    sram_arbiter #(.WAIT_CYCLES(2)) dut (
        .Clk(clk), .Reset(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_ready(dbg_ready),
        .gnt(gnt),
        .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n), .SRAM_LB_N(lb_n), .SRAM_UB_N(ub_n),
        .SRAM_ADDR(sram_addr), .SRAM_DQ(dq)
    );

    sram_arbiter #(.WAIT_CYCLES(1)) dut1 (
        .Clk(clk), .Reset(rst),
        .cpu_req(c1_req), .cpu_we(1'b0), .cpu_addr(c1_addr), .cpu_wdata(16'h0000),
        .cpu_rdata(c1_rdata), .cpu_ready(c1_ready),
        .dbg_req(1'b0), .dbg_we(1'b0), .dbg_addr(16'h0000), .dbg_wdata(16'h0000),
        .dbg_rdata(c1_dbg_rdata), .dbg_ready(c1_dbg_ready),
        .gnt(c1_gnt),
        .SRAM_CE_N(c1_ce_n), .SRAM_OE_N(c1_oe_n), .SRAM_WE_N(c1_we_n), .SRAM_LB_N(c1_lb_n),
        .SRAM_UB_N(c1_ub_n), .SRAM_ADDR(c1_sram_addr), .SRAM_DQ(dq1)
    );

    // SRAM behavioural models
    logic [15:0] mem [0:65535];
    assign dq  = (!ce_n && !oe_n && we_n) ? mem[sram_addr[15:0]] : 16'hzzzz;
    assign dq1 = (!c1_ce_n && !c1_oe_n) ? 16'hA5C3 : 16'hzzzz;
    always @(posedge clk) begin
        if (!ce_n && !we_n) mem[sram_addr[15:0]] <= dq;
    end

    typedef struct {
        bit          is_dbg;
        logic [15:0] cpu_rd;
        logic [15:0] dbg_rd;
    } exp_t;
    exp_t        sb_q[$];
    logic [15:0] trk_cpu_rd, trk_dbg_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input bit is_dbg, input bit we, input logic [15:0] rd);
        exp_t e;
        if (!we) begin
            if (is_dbg) trk_dbg_rd = rd;
            else        trk_cpu_rd = rd;
        end
        e.is_dbg = is_dbg;
        e.cpu_rd = trk_cpu_rd;
        e.dbg_rd = trk_dbg_rd;
        sb_q.push_back(e);
    endtask

    // Scoreboard monitor plus per-cycle bus invariants
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            chk("oe_we_overlap", {31'd0, (!oe_n && !we_n)}, 32'd0);
            if (cpu_ready || dbg_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_ready", {30'd0, dbg_ready, cpu_ready}, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("ready_port", {30'd0, dbg_ready, cpu_ready}, e.is_dbg ? 32'd2 : 32'd1);
                    chk("done_gnt", {30'd0, gnt}, e.is_dbg ? 32'd2 : 32'd1);
                    chk("cpu_rdata", {16'd0, cpu_rdata}, {16'd0, e.cpu_rd});
                    chk("dbg_rdata", {16'd0, dbg_rdata}, {16'd0, e.dbg_rd});
                end
            end
        end
    end

    task automatic do_req(input bit is_dbg, input bit we, input logic [15:0] addr,
                          input logic [15:0] wdata, input logic [15:0] rd);
        int cyc = 0;
        int oe_c = 0;
        int we_c = 0;
        bit got = 1'b0;
        bit addr_ok = 1'b1;
        bit dq_ok = 1'b1;
        bit gnt_ok = 1'b1;
        push_exp(is_dbg, we, rd);
        @(negedge clk);
        if (is_dbg) begin
            dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
        while (!got && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (!oe_n) oe_c++;
            if (!we_n) begin
                we_c++;
                if (dq !== wdata) dq_ok = 1'b0;
            end
            if (sram_addr !== {4'h0, addr}) addr_ok = 1'b0;
            if (gnt !== (is_dbg ? 2'b10 : 2'b01)) gnt_ok = 1'b0;
            if (is_dbg ? dbg_ready : cpu_ready) got = 1'b1;
        end
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        chk("latency", cyc, 32'd4);
        chk("oe_low_cycles", oe_c, we ? 32'd0 : 32'd3);
        chk("we_low_cycles", we_c, we ? 32'd2 : 32'd0);
        chk("sram_addr_held", {31'd0, addr_ok}, 32'd1);
        chk("dq_during_we", {31'd0, dq_ok}, 32'd1);
        chk("gnt_held", {31'd0, gnt_ok}, 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rdy;
        int cyc;
        bit got;
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        mem[16'h0030] = 16'h1234;
        rst = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 16'h0000;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 16'h0000; dbg_wdata = 16'h0000;
        c1_req = 1'b0; c1_addr = 16'h0000;
        trk_cpu_rd = 16'h0000; trk_dbg_rd = 16'h0000;
        repeat (3) @(negedge clk);

        chk("rst_strobes", {27'd0, ce_n, oe_n, we_n, lb_n, ub_n}, 32'h1F);
        chk("rst_addr", {12'd0, sram_addr}, 32'd0);
        chk("rst_gnt", {30'd0, gnt}, 32'd0);
        chk("rst_ready", {30'd0, cpu_ready, dbg_ready}, 32'd0);
        chk("rst_rdata", {cpu_rdata, dbg_rdata}, 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;

        do_req(1'b0, 1'b0, 16'h0030, 16'h0000, 16'h1234);
        do_req(1'b0, 1'b1, 16'h3000, 16'hBEEF, 16'h0000);
        chk("mem_3000", {16'd0, mem[16'h3000]}, 32'h0000BEEF);
        do_req(1'b1, 1'b1, 16'h0100, 16'h5A5A, 16'h0000);
        chk("mem_0100", {16'd0, mem[16'h0100]}, 32'h00005A5A);
        do_req(1'b0, 1'b0, 16'h0100, 16'h0000, 16'h5A5A);
        do_req(1'b1, 1'b0, 16'h0030, 16'h0000, 16'h1234);

        // Tie with both held: CPU, debug, CPU, debug.
        push_exp(1'b0, 1'b0, 16'hBEEF);
        push_exp(1'b1, 1'b0, 16'h5A5A);
        push_exp(1'b0, 1'b0, 16'hBEEF);
        push_exp(1'b1, 1'b0, 16'h5A5A);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h3000;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h0100;
        rdy = 0; cyc = 0;
        while (rdy < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (cpu_ready || dbg_ready) rdy++;
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        chk("alt_ready_count", rdy, 32'd4);
        @(negedge clk);

        // Reset in the second ACCESS cycle of a write.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0200; cpu_wdata = 16'h1111;
        repeat (3) @(negedge clk);
        chk("abort_we_low", {31'd0, we_n}, 32'd0);
        rst = 1'b1; cpu_req = 1'b0;
        @(negedge clk);
        chk("abort_strobes", {27'd0, ce_n, oe_n, we_n, lb_n, ub_n}, 32'h1F);
        chk("abort_gnt", {30'd0, gnt}, 32'd0);
        chk("abort_addr", {12'd0, sram_addr}, 32'd0);
        chk("abort_ready", {30'd0, cpu_ready, dbg_ready}, 32'd0);
        chk("abort_rdata", {cpu_rdata, dbg_rdata}, 32'd0);
        rst = 1'b0;
        trk_cpu_rd = 16'h0000; trk_dbg_rd = 16'h0000;

        // First tie after reset goes to the CPU.
        push_exp(1'b0, 1'b0, 16'h1234);
        push_exp(1'b1, 1'b0, 16'hBEEF);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0030;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h3000;
        rdy = 0; cyc = 0;
        while (rdy < 2 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cpu_ready) begin cpu_req = 1'b0; rdy++; end
            if (dbg_ready) begin dbg_req = 1'b0; rdy++; end
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        chk("post_rst_ready_count", rdy, 32'd2);
        @(negedge clk);

        // Single-wait build: req dropped in SETUP still completes.
        c1_req = 1'b1; c1_addr = 16'h0042;
        cyc = 0; got = 1'b0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) c1_req = 1'b0;
            if (c1_ready) got = 1'b1;
        end
        chk("w1_latency", cyc, 32'd3);
        chk("w1_rdata", {16'd0, c1_rdata}, 32'h0000A5C3);
        @(negedge clk);
        chk("w1_no_repeat", {29'd0, c1_ready, c1_gnt}, 32'd0);

        repeat (2) @(negedge clk);
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
